// File: rtl/dds_tune_ctrl.sv
// dds_tune_ctrl: push-button tuning controller for the DDS frequency tuning word.
// A single step is taken on each press. After HOLD_CYC cycles of holding, the
// word auto-repeats every REPEAT_CYC cycles. The step-select button cycles
// through power-of-two step sizes. By default the word saturates at 0 and all-ones.
// Optional macro DDS_TUNE_WRAP_EN: when defined, the tuning word uses modular
// arithmetic, ftw_valid pulses on every step, and at_limit is held at 0.
module dds_tune_ctrl #(
    parameter int                FTW_W         = 32,
    parameter int                STEP_NUM      = 8,
    parameter int                STEP_LOG2_INC = 4,
    parameter int                HOLD_CYC      = 50000000,
    parameter int                REPEAT_CYC    = 5000000,
    parameter logic [FTW_W-1:0]  FTW_RST       = '0,
    localparam int               IDX_W         = (STEP_NUM > 1) ? $clog2(STEP_NUM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_state,
    input  logic             dn_state,
    input  logic             step_state,
    output logic [FTW_W-1:0] ftw,
    output logic [IDX_W-1:0] step_idx,
    output logic             ftw_valid,
    output logic             at_limit
);

    localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(STEP_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_up_q, dir_up_d;
    logic [FTW_W-1:0] ftw_q, ftw_d;
    logic             ftw_valid_q, ftw_valid_d;
    logic [IDX_W-1:0] step_idx_q, step_idx_d;
    logic             up_prev_q, dn_prev_q, step_prev_q;

    logic             rise_up, rise_dn, rise_step;
    logic             dir_held, opp_held;
    logic             do_step;
    logic [FTW_W-1:0] step_amt, up_val, dn_val, ftw_next;

    // State, counter, tuning word and edge-detect history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dir_up_q    <= 1'b1;
            ftw_q       <= FTW_RST;
            ftw_valid_q <= 1'b0;
            step_idx_q  <= '0;
            // Start history high so a button held through reset yields no edge
            up_prev_q   <= 1'b1;
            dn_prev_q   <= 1'b1;
            step_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_up_q    <= dir_up_d;
            ftw_q       <= ftw_d;
            ftw_valid_q <= ftw_valid_d;
            step_idx_q  <= step_idx_d;
            up_prev_q   <= up_state;
            dn_prev_q   <= dn_state;
            step_prev_q <= step_state;
        end
    end

    // Edge detection, step arithmetic, FSM next state and step-size selection
    always_comb begin
        rise_up   = up_state & ~up_prev_q;
        rise_dn   = dn_state & ~dn_prev_q;
        rise_step = step_state & ~step_prev_q;

        // Decisions in this cycle use the step size currently on step_idx
        step_amt = FTW_W'(1) << (int'(step_idx_q) * STEP_LOG2_INC);

`ifdef DDS_TUNE_WRAP_EN
        up_val = ftw_q + step_amt;
        dn_val = ftw_q - step_amt;
`else
        up_val = (ftw_q > ({FTW_W{1'b1}} - step_amt)) ? {FTW_W{1'b1}} : (ftw_q + step_amt);
        dn_val = (ftw_q < step_amt) ? '0 : (ftw_q - step_amt);
`endif

        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        do_step  = 1'b0;
        dir_held = dir_up_q ? up_state : dn_state;
        opp_held = dir_up_q ? dn_state : up_state;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // A rise with the other button down is treated as ambiguous
                if (rise_up && !dn_state) begin
                    do_step  = 1'b1;
                    dir_up_d = 1'b1;
                    state_d  = ST_HOLD;
                end else if (rise_dn && !up_state) begin
                    do_step  = 1'b1;
                    dir_up_d = 1'b0;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Release or opposite press takes priority over terminal count
                if (!dir_held || opp_held) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    do_step = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (!dir_held || opp_held) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    do_step = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        ftw_next    = dir_up_d ? up_val : dn_val;
        ftw_d       = ftw_q;
        ftw_valid_d = 1'b0;
        if (do_step) begin
            ftw_d = ftw_next;
`ifdef DDS_TUNE_WRAP_EN
            ftw_valid_d = 1'b1;
`else
            ftw_valid_d = (ftw_next != ftw_q);
`endif
        end

        step_idx_d = step_idx_q;
        if (rise_step) begin
            step_idx_d = (step_idx_q == IDX_LAST) ? '0 : (step_idx_q + IDX_W'(1));
        end
    end

    assign ftw       = ftw_q;
    assign ftw_valid = ftw_valid_q;
    assign step_idx  = step_idx_q;
`ifdef DDS_TUNE_WRAP_EN
    assign at_limit  = 1'b0;
`else
    assign at_limit  = (ftw_q == '0) || (ftw_q == {FTW_W{1'b1}});
`endif

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// tb_dds_tune_ctrl: directed tests of press, auto-repeat, step select,
// saturation/wrap limits, opposite-button cancel and reset with held buttons.
module tb_dds_tune_ctrl;

    localparam int FTW_W = 8;
`ifdef DDS_TUNE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             up_state = 1'b0;
    logic             dn_state = 1'b0;
    logic             step_state = 1'b0;
    logic [FTW_W-1:0] ftw;
    logic [0:0]       step_idx;
    logic             ftw_valid;
    logic             at_limit;

    int errors = 0;
    int checks = 0;

    dds_tune_ctrl #(
        .FTW_W(8), .STEP_NUM(2), .STEP_LOG2_INC(4),
        .HOLD_CYC(8), .REPEAT_CYC(4), .FTW_RST(8'h00)
    ) dut (
        .clk(clk), .rst(rst), .up_state(up_state), .dn_state(dn_state),
        .step_state(step_state), .ftw(ftw), .step_idx(step_idx),
        .ftw_valid(ftw_valid), .at_limit(at_limit)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are observed on the falling edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; up_state = 1'b0; dn_state = 1'b0; step_state = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input bit is_up);
        if (is_up) up_state = 1'b1; else dn_state = 1'b1;
        @(negedge clk);
        up_state = 1'b0; dn_state = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ftw !== 8'h00) begin errors++; $display("FAIL reset_ftw: got %h want 00", ftw); end
        checks++; if (step_idx !== 1'b0) begin errors++; $display("FAIL reset_idx: got %b want 0", step_idx); end
        checks++; if (ftw_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ftw_valid); end
        checks++; if (at_limit !== !WRAP) begin errors++; $display("FAIL reset_limit: got %b want %b", at_limit, !WRAP); end
        $display("test_reset: ftw=%h idx=%b limit=%b", ftw, step_idx, at_limit);
    endtask

    task automatic test_single_press();
        up_state = 1'b1;
        @(negedge clk);
        checks++; if (ftw !== 8'h01) begin errors++; $display("FAIL press_ftw: got %h want 01", ftw); end
        checks++; if (ftw_valid !== 1'b1) begin errors++; $display("FAIL press_valid: got %b want 1", ftw_valid); end
        checks++; if (at_limit !== 1'b0) begin errors++; $display("FAIL press_limit: got %b want 0", at_limit); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (ftw_valid !== 1'b0) begin errors++; $display("FAIL press_held_valid: got %b want 0", ftw_valid); end
        end
        up_state = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (ftw !== 8'h01 || ftw_valid !== 1'b0) begin
                errors++; $display("FAIL press_after: cyc %0d got ftw=%h v=%b want 01/0", i, ftw, ftw_valid);
            end
        end
        $display("test_single_press: ftw=%h", ftw);
    endtask

    task automatic test_auto_repeat();
        int n = 0;
        bit exp_v;
        do_reset();
        up_state = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp_v = (k == 0) || (k == 8) || (k == 12) || (k == 16);
            if (exp_v) n++;
            checks++;
            if (ftw !== 8'(n) || ftw_valid !== exp_v) begin
                errors++; $display("FAIL repeat_seq: cyc %0d got ftw=%h v=%b want %h/%b", k, ftw, ftw_valid, 8'(n), exp_v);
            end
        end
        up_state = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (ftw !== 8'h04 || ftw_valid !== 1'b0) begin
                errors++; $display("FAIL repeat_release: cyc %0d got ftw=%h v=%b want 04/0", i, ftw, ftw_valid);
            end
        end
        $display("test_auto_repeat: ftw=%h", ftw);
    endtask

    task automatic test_step_saturate();
        logic [7:0] e1, e2;
        do_reset();
        repeat (5) press(1'b1);
        step_state = 1'b1;
        @(negedge clk);
        step_state = 1'b0;
        checks++; if (step_idx !== 1'b1) begin errors++; $display("FAIL step_sel: got %b want 1", step_idx); end
        @(negedge clk);
        repeat (15) press(1'b1);
        checks++; if (ftw !== 8'hF5) begin errors++; $display("FAIL step_build: got %h want F5", ftw); end
        e1 = WRAP ? 8'h05 : 8'hFF;
        e2 = WRAP ? 8'h15 : 8'hFF;
        up_state = 1'b1;
        @(negedge clk);
        checks++; if (ftw !== e1) begin errors++; $display("FAIL sat_up_ftw: got %h want %h", ftw, e1); end
        checks++; if (ftw_valid !== 1'b1) begin errors++; $display("FAIL sat_up_valid: got %b want 1", ftw_valid); end
        checks++; if (at_limit !== !WRAP) begin errors++; $display("FAIL sat_up_limit: got %b want %b", at_limit, !WRAP); end
        up_state = 1'b0;
        @(negedge clk);
        up_state = 1'b1;
        @(negedge clk);
        checks++; if (ftw !== e2) begin errors++; $display("FAIL sat_again_ftw: got %h want %h", ftw, e2); end
        checks++; if (ftw_valid !== WRAP) begin errors++; $display("FAIL sat_again_valid: got %b want %b", ftw_valid, WRAP); end
        up_state = 1'b0;
        @(negedge clk);
        step_state = 1'b1;
        @(negedge clk);
        step_state = 1'b0;
        checks++; if (step_idx !== 1'b0) begin errors++; $display("FAIL step_wrap: got %b want 0", step_idx); end
        @(negedge clk);
        $display("test_step_saturate: ftw=%h idx=%b", ftw, step_idx);
    endtask

    task automatic test_down_limit();
        logic [7:0] e;
        do_reset();
        dn_state = 1'b1;
        @(negedge clk);
        e = WRAP ? 8'hFF : 8'h00;
        checks++; if (ftw !== e) begin errors++; $display("FAIL dn_zero_ftw: got %h want %h", ftw, e); end
        checks++; if (ftw_valid !== WRAP) begin errors++; $display("FAIL dn_zero_valid: got %b want %b", ftw_valid, WRAP); end
        checks++; if (at_limit !== !WRAP) begin errors++; $display("FAIL dn_zero_limit: got %b want %b", at_limit, !WRAP); end
        dn_state = 1'b0;
        do_reset();
        press(1'b1);
        step_state = 1'b1;
        @(negedge clk);
        step_state = 1'b0;
        @(negedge clk);
        dn_state = 1'b1;
        @(negedge clk);
        e = WRAP ? 8'hF1 : 8'h00;
        checks++; if (ftw !== e) begin errors++; $display("FAIL dn_big_ftw: got %h want %h", ftw, e); end
        checks++; if (ftw_valid !== 1'b1) begin errors++; $display("FAIL dn_big_valid: got %b want 1", ftw_valid); end
        dn_state = 1'b0;
        @(negedge clk);
        $display("test_down_limit: ftw=%h", ftw);
    endtask

    task automatic test_opposite();
        do_reset();
        up_state = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (ftw !== 8'h02) begin errors++; $display("FAIL opp_pre: got %h want 02", ftw); end
        dn_state = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (ftw !== 8'h02 || ftw_valid !== 1'b0) begin
                errors++; $display("FAIL opp_cancel: cyc %0d got ftw=%h v=%b want 02/0", i, ftw, ftw_valid);
            end
        end
        up_state = 1'b0; dn_state = 1'b0;
        repeat (2) @(negedge clk);
        up_state = 1'b1; dn_state = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (ftw !== 8'h02 || ftw_valid !== 1'b0) begin
                errors++; $display("FAIL both_rise: cyc %0d got ftw=%h v=%b want 02/0", i, ftw, ftw_valid);
            end
        end
        up_state = 1'b0; dn_state = 1'b0;
        repeat (2) @(negedge clk);
        up_state = 1'b1;
        @(negedge clk);
        checks++;
        if (ftw !== 8'h03 || ftw_valid !== 1'b1) begin
            errors++; $display("FAIL opp_recover: got ftw=%h v=%b want 03/1", ftw, ftw_valid);
        end
        up_state = 1'b0;
        @(negedge clk);
        $display("test_opposite: ftw=%h", ftw);
    endtask

    task automatic test_reset_hold();
        @(negedge clk);
        rst = 1'b1; up_state = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (ftw !== 8'h00 || ftw_valid !== 1'b0) begin
                errors++; $display("FAIL hold_thru_rst: cyc %0d got ftw=%h v=%b want 00/0", i, ftw, ftw_valid);
            end
        end
        up_state = 1'b0;
        repeat (2) @(negedge clk);
        step_state = 1'b1;
        @(negedge clk);
        step_state = 1'b0;
        up_state = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (ftw !== 8'h20 || step_idx !== 1'b1) begin
            errors++; $display("FAIL rst_pre: got ftw=%h idx=%b want 20/1", ftw, step_idx);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ftw !== 8'h00 || step_idx !== 1'b0 || ftw_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_repeat: got ftw=%h idx=%b v=%b want 00/0/0", ftw, step_idx, ftw_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (ftw !== 8'h00 || ftw_valid !== 1'b0) begin
                errors++; $display("FAIL rst_after: cyc %0d got ftw=%h v=%b want 00/0", i, ftw, ftw_valid);
            end
        end
        up_state = 1'b0;
        @(negedge clk);
        up_state = 1'b1;
        @(negedge clk);
        checks++;
        if (ftw !== 8'h01 || ftw_valid !== 1'b1) begin
            errors++; $display("FAIL rst_recover: got ftw=%h v=%b want 01/1", ftw, ftw_valid);
        end
        up_state = 1'b0;
        @(negedge clk);
        $display("test_reset_hold: ftw=%h", ftw);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_auto_repeat();
        test_step_saturate();
        test_down_limit();
        test_opposite();
        test_reset_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dds_tune_ctrl.md
Name: dds_tune_ctrl

Overview:
Button-driven tuning controller for the DDS phase accumulator. Consumes debounced push-button levels from the debouncer instances (up, down, step-select) and sequences the frequency tuning word (FTW): single step on press, auto-repeat on hold, selectable step size, with saturation at the range limits. Sits between the debouncers and the phase accumulator's FTW load port.

Parameters:
FTW_W, 32, tuning word width in bits
STEP_NUM, 8, number of selectable step sizes; step_idx ranges 0..STEP_NUM-1
STEP_LOG2_INC, 4, log2 ratio between adjacent step sizes; step = 1 << (step_idx*STEP_LOG2_INC); requires (STEP_NUM-1)*STEP_LOG2_INC < FTW_W
HOLD_CYC, 50000000, cycles a button must be held before auto-repeat starts (>=2)
REPEAT_CYC, 5000000, cycles between auto-repeat steps (>=2)
FTW_RST, 0, FTW value loaded at reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
up_state  in  1  debounced level, up button (1 = pressed)
dn_state  in  1  debounced level, down button
step_state  in  1  debounced level, step-size button
ftw  out  FTW_W  current tuning word to phase accumulator
step_idx  out  clog2(STEP_NUM)  current step-size index
ftw_valid  out  1  one-cycle strobe, high in the cycle ftw shows a new value
at_limit  out  1  high while ftw == 0 or ftw == all-ones

Behaviour:
- Reset (sync, rst=1 at posedge): ftw=FTW_RST, step_idx=0, ftw_valid=0, FSM=IDLE, counter=0; edge-detect history regs for up/dn/step load 1 (a button held through reset produces no edge). at_limit follows ftw combinationally from reset value.
- Edge detect: rise_x = x_state & ~x_prev; x_prev <= x_state every cycle.
- Step apply: on the clock edge where a step is decided, ftw updates; new value and ftw_valid=1 visible next cycle (latency 1 cycle from sampled edge/count terminal). ftw_valid=0 in all other cycles.
- Saturation: up: if ftw > MAX-step then ftw=MAX else ftw+step; down: if ftw < step then 0 else ftw-step. ftw_valid pulses only when ftw actually changes (no pulse when already at limit).
- FSM states IDLE, HOLD, REPEAT; dir register (up/down).
  IDLE: rise_up & ~dn_state -> step up, dir=up, counter=0, ->HOLD. rise_dn & ~up_state -> step down, dir=down, ->HOLD. Both rising same cycle, or rise on one while other held -> no step, stay IDLE.
  HOLD: dir button released -> IDLE. Opposite button pressed -> IDLE, no step. counter==HOLD_CYC-1 -> step in dir, counter=0, ->REPEAT; else counter++.
  REPEAT: release or opposite press -> IDLE, no step. counter==REPEAT_CYC-1 -> step, counter=0; else counter++.
  Release and terminal count in same cycle: release wins, no step.
- Step select: rise_step in any state -> step_idx = (step_idx==STEP_NUM-1) ? 0 : step_idx+1. A step decided in the same cycle uses the old step_idx.
- Counter width: clog2(max(HOLD_CYC,REPEAT_CYC)).

Optional Feature:
DDS_TUNE_WRAP_EN: defined -> modular arithmetic (ftw+step / ftw-step mod 2^FTW_W), ftw_valid pulses on every step, at_limit tied 0. Undefined -> saturating behaviour above.

Test Plan (FTW_W=8, STEP_NUM=2, STEP_LOG2_INC=4, HOLD_CYC=8, REPEAT_CYC=4, FTW_RST=0):
1. Reset, pulse up_state high 3 cycles then low -> ftw 0->1, single ftw_valid, FSM back to IDLE, at_limit 1->0.
2. Hold up_state 20 cycles -> steps at press+1, then +8 cycles, then every 4 cycles: ftw=1,2,3,4 at expected cycles; release -> no further steps.
3. Pulse step_state, then press up from ftw=0xF5 -> step_idx=1, ftw=0xFF (saturated), at_limit=1; second press -> no change, no ftw_valid.
4. ftw=0, press down -> ftw stays 0, no ftw_valid, at_limit=1; with DDS_TUNE_WRAP_EN -> ftw=0xFF, ftw_valid pulse, at_limit=0.
5. Hold up into REPEAT, assert dn_state -> no step, IDLE; up and dn rising same cycle -> no change.
6. Hold up_state through rst deassert -> no step after reset; assert rst mid-REPEAT -> ftw=0, step_idx=0, IDLE next cycle.
